// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter
// Measures the high time and rising-edge count of a PWM stream over
// back-to-back windows of WINDOW clock cycles, aligned to the first rising
// edge after enable. Each window's result goes out through a valid/ready
// output register; a result that cannot be stored sets a sticky overrun flag.
//
// Build option: define PWM_DUTY_SYNC_EN to pass pwm_in through a 2-flop
// synchronizer before it is sampled. This adds 2 cycles of input latency.
// Without it, pwm_in is assumed to come from the same clock domain.

module pwm_duty_meter #(
  parameter int WINDOW = 64,
  parameter int CNT_W  = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] duty_count,
  output logic [CNT_W-1:0] edge_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t state, state_next;

  logic             s;
  logic             s_prev;
  logic             rise;

  logic [CNT_W-1:0] high_acc;
  logic [CNT_W-1:0] edge_acc;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] high_next;
  logic [CNT_W-1:0] edge_next;

  logic             arm_hit;
  logic             measuring;
  logic             window_end;
  logic             load;
  logic             drop;

`ifdef PWM_DUTY_SYNC_EN
  logic sync_q1;
  logic sync_q2;

  // Two-flop synchronizer for an asynchronous PWM source
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= pwm_in;
      sync_q2 <= sync_q1;
    end
  end

  assign s = sync_q2;
`else
  assign s = pwm_in;
`endif

  // Previous sample, tracked continuously so edges across window boundaries are seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_prev <= 1'b0;
    end else begin
      s_prev <= s;
    end
  end

  assign rise = s & ~s_prev;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: dropping enable always returns to IDLE
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = ARM;
        ARM:     if (rise) state_next = MEASURE;
        MEASURE: state_next = MEASURE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Control decodes from the current state
  always_comb begin
    arm_hit    = 1'b0;
    measuring  = 1'b0;
    window_end = 1'b0;
    if (enable) begin
      case (state)
        ARM:     arm_hit   = rise;
        MEASURE: begin
          measuring  = 1'b1;
          window_end = (idx == LAST_IDX);
        end
        default: begin
          arm_hit   = 1'b0;
          measuring = 1'b0;
        end
      endcase
    end
  end

  // Accumulator values including the sample presented this cycle
  always_comb begin
    high_next = high_acc + (s ? ONE : '0);
    edge_next = edge_acc + (rise ? ONE : '0);
  end

  // Window accumulators and sample index; the aligning edge is sample 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_acc <= '0;
      edge_acc <= '0;
      idx      <= '0;
    end else if (!enable) begin
      high_acc <= '0;
      edge_acc <= '0;
      idx      <= '0;
    end else if (arm_hit) begin
      high_acc <= ONE;
      edge_acc <= ONE;
      idx      <= ONE;
    end else if (measuring) begin
      if (window_end) begin
        high_acc <= '0;
        edge_acc <= '0;
        idx      <= '0;
      end else begin
        high_acc <= high_next;
        edge_acc <= edge_next;
        idx      <= idx + ONE;
      end
    end
  end

  // A window result is stored if the register is empty or being drained this cycle
  assign load = window_end && (!out_valid || out_ready);
  assign drop = window_end && out_valid && !out_ready;

  // Output register with valid/ready handshake; contents survive enable dropping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_count <= '0;
      edge_count <= '0;
      out_valid  <= 1'b0;
    end else if (load) begin
      duty_count <= high_next;
      edge_count <= edge_next;
      out_valid  <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Sticky overrun flag, cleared only by dropping enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (!enable) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end
  end

endmodule
